// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arbState_t;

    // Default SRAM window, byte addresses, both ends inclusive.
    localparam logic [31:0] SRAM_BEGIN_DEFAULT = 32'h1004_0000;
    localparam logic [31:0] SRAM_END_DEFAULT   = 32'h1024_0000;

    // Wide enough for SRAM_WAIT values 0..15.
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin selector: on contention, the port not served last wins.
module mem_arb_rr
(
    input  logic       iReq0,
    input  logic       iReq1,
    input  logic       iLastServed,
    output logic [1:0] oGrant,
    output logic       oWinner
);

    // Pick the winner; an uncontested request wins outright.
    always_comb begin
        oWinner = 1'b0;
        if (iReq0 && iReq1) begin
            oWinner = ~iLastServed;
        end else if (iReq1) begin
            oWinner = 1'b1;
        end
        oGrant = 2'b00;
        if (iReq0 || iReq1) begin
            oGrant = oWinner ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: CPU (port 0) and DMA/video (port 1) share one
// memory bus; SRAM-region accesses take extra wait cycles.
//
// state  | meaning
// IDLE   | bus idle, requests sampled, winner latched
// ACCESS | strobes driven from the latched request; wait counter runs down
// DONE   | one-cycle ack pulse to the owner
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned  SRAM_WAIT      = 2,
    parameter logic [31:0]  BEGINNING_SRAM = SRAM_BEGIN_DEFAULT,
    parameter logic [31:0]  END_SRAM       = SRAM_END_DEFAULT
)
(
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iReq0,
    input  logic        iReq1,
    input  logic        iWe0,
    input  logic        iWe1,
    input  logic [31:0] iAddr0,
    input  logic [31:0] iAddr1,
    input  logic [31:0] iWData0,
    input  logic [31:0] iWData1,
    input  logic [3:0]  iBE0,
    input  logic [3:0]  iBE1,
    output logic        oAck0,
    output logic        oAck1,
    output logic [31:0] oRData0,
    output logic [31:0] oRData1,
    output logic        oMemRead,
    output logic        oMemWrite,
    output logic [31:0] oAddress,
    output logic [31:0] oWriteData,
    output logic [3:0]  oByteEnable,
    input  logic [31:0] iMemData
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(SRAM_WAIT);

    arbState_t              state;
    arbState_t              nextState;

    logic                   latWe;
    logic [31:0]            latAddr;
    logic [31:0]            latWData;
    logic [3:0]             latBE;
    logic                   owner;
    logic                   firstAccess;
    logic                   lastServed;
    logic [WAIT_CNT_W-1:0]  waitCnt;
    logic [31:0]            rData0;
    logic [31:0]            rData1;

    logic [1:0]             grant;
    logic                   winner;
    logic                   anyReq;
    logic                   inSram;
    logic                   lastAccess;

    logic                   winWe;
    logic [31:0]            winAddr;
    logic [31:0]            winWData;
    logic [3:0]             winBE;

    mem_arb_rr uRr (
        .iReq0       (iReq0),
        .iReq1       (iReq1),
        .iLastServed (lastServed),
        .oGrant      (grant),
        .oWinner     (winner)
    );

    assign anyReq = |grant;

    // Region decode looks only at the latched address, never the live inputs.
    assign inSram = (latAddr >= BEGINNING_SRAM) && (latAddr <= END_SRAM);

    // Terminal count: non-SRAM accesses finish at once, SRAM ones when the counter hits zero.
    assign lastAccess = (state == ACCESS) && (!inSram || (waitCnt == '0));

    // Route the winning port's request fields toward the latch.
    always_comb begin
        winWe    = winner ? iWe1    : iWe0;
        winAddr  = winner ? iAddr1  : iAddr0;
        winWData = winner ? iWData1 : iWData0;
        winBE    = winner ? iBE1    : iBE0;
    end

    // State register.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state and bus/ack outputs; memory side is quiet outside ACCESS.
    always_comb begin
        nextState   = state;
        oMemRead    = 1'b0;
        oMemWrite   = 1'b0;
        oAddress    = '0;
        oWriteData  = '0;
        oByteEnable = '0;
        oAck0       = 1'b0;
        oAck1       = 1'b0;
        case (state)
            IDLE: begin
                if (anyReq) begin
                    nextState = ACCESS;
                end
            end
            ACCESS: begin
                oAddress    = latAddr;
                oWriteData  = latWData;
                oByteEnable = latBE;
                oMemRead    = ~latWe;
                oMemWrite   = latWe & firstAccess;
                if (lastAccess) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                oAck0     = ~owner;
                oAck1     = owner;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Request latch, wait counter, round-robin pointer and read-data capture.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            latWe       <= 1'b0;
            latAddr     <= '0;
            latWData    <= '0;
            latBE       <= '0;
            owner       <= 1'b0;
            firstAccess <= 1'b0;
            lastServed  <= 1'b1;
            waitCnt     <= '0;
            rData0      <= '0;
            rData1      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        latWe       <= winWe;
                        latAddr     <= winAddr;
                        latWData    <= winWData;
                        latBE       <= winBE;
                        owner       <= winner;
                        lastServed  <= winner;
                        firstAccess <= 1'b1;
                        waitCnt     <= WAIT_LOAD;
                    end
                end
                ACCESS: begin
                    firstAccess <= 1'b0;
                    if (!lastAccess && (waitCnt != '0)) begin
                        waitCnt <= waitCnt - 1'b1;
                    end
                    if (lastAccess && !latWe) begin
                        if (owner) begin
                            rData1 <= iMemData;
                        end else begin
                            rData0 <= iMemData;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign oRData0 = rData0;
    assign oRData1 = rData1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level timing model checked every cycle,
// plus directed transactions with hand-computed latencies and data.
module tb_mem_arbiter;

    localparam int          W      = 2;
    localparam logic [31:0] SBEGIN = 32'h1004_0000;
    localparam logic [31:0] SEND   = 32'h1024_0000;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iReq0 = 1'b0, iReq1 = 1'b0;
    logic        iWe0 = 1'b0, iWe1 = 1'b0;
    logic [31:0] iAddr0 = '0, iAddr1 = '0;
    logic [31:0] iWData0 = '0, iWData1 = '0;
    logic [3:0]  iBE0 = '0, iBE1 = '0;
    logic [31:0] iMemData = '0;
    logic        oAck0, oAck1;
    logic [31:0] oRData0, oRData1;
    logic        oMemRead, oMemWrite;
    logic [31:0] oAddress, oWriteData;
    logic [3:0]  oByteEnable;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(
        .SRAM_WAIT      (W),
        .BEGINNING_SRAM (SBEGIN),
        .END_SRAM       (SEND)
    ) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iReq0       (iReq0),
        .iReq1       (iReq1),
        .iWe0        (iWe0),
        .iWe1        (iWe1),
        .iAddr0      (iAddr0),
        .iAddr1      (iAddr1),
        .iWData0     (iWData0),
        .iWData1     (iWData1),
        .iBE0        (iBE0),
        .iBE1        (iBE1),
        .oAck0       (oAck0),
        .oAck1       (oAck1),
        .oRData0     (oRData0),
        .oRData1     (oRData1),
        .oMemRead    (oMemRead),
        .oMemWrite   (oMemWrite),
        .oAddress    (oAddress),
        .oWriteData  (oWriteData),
        .oByteEnable (oByteEnable),
        .iMemData    (iMemData)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit isSram(input logic [31:0] a);
        return (a >= SBEGIN) && (a <= SEND);
    endfunction

    // ---------------- transaction-level model ----------------
    // A granted transaction occupies 'len' bus cycles after the grant cycle,
    // then one ack cycle; the bus is free again the cycle after that.
    int          cyc = 0;
    int          mGrant = 0;
    int          mLen = 0;
    int          mD = 0;
    bit          mActive = 0;
    bit          mLast = 1;
    bit          mOwner = 0;
    bit          mWe = 0;
    logic [31:0] mAddr = '0, mWData = '0;
    logic [3:0]  mBE = '0;
    logic [31:0] mRD0 = '0, mRD1 = '0;

    always @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            mActive = 0;
            mLast   = 1;
            mRD0    = '0;
            mRD1    = '0;
            cyc     = 0;
        end else begin
            mD = cyc - mGrant;
            if (mActive && mD == mLen && !mWe) begin
                if (mOwner) mRD1 = iMemData;
                else        mRD0 = iMemData;
            end
            if (!mActive || mD >= mLen + 2) begin
                if (iReq0 || iReq1) begin
                    mOwner  = (iReq0 && iReq1) ? !mLast : iReq1;
                    mLast   = mOwner;
                    mWe     = mOwner ? iWe1    : iWe0;
                    mAddr   = mOwner ? iAddr1  : iAddr0;
                    mWData  = mOwner ? iWData1 : iWData0;
                    mBE     = mOwner ? iBE1    : iBE0;
                    mLen    = isSram(mAddr) ? 1 + W : 1;
                    mGrant  = cyc;
                    mActive = 1;
                end
            end
            cyc++;
        end
    end

    // Compare every cycle against the model, away from the active edge.
    always @(negedge iCLK) begin
        if (!iRST) begin
            int  d;
            bit  acc;
            bit  ack;
            d   = cyc - mGrant;
            acc = mActive && d >= 1 && d <= mLen;
            ack = mActive && d == mLen + 1;
            chk("mdl_memRead",  oMemRead,    acc && !mWe);
            chk("mdl_memWrite", oMemWrite,   acc && mWe && d == 1);
            chk("mdl_address",  oAddress,    acc ? mAddr  : 32'h0);
            chk("mdl_wdata",    oWriteData,  acc ? mWData : 32'h0);
            chk("mdl_be",       oByteEnable, acc ? mBE    : 4'h0);
            chk("mdl_ack0",     oAck0,       ack && !mOwner);
            chk("mdl_ack1",     oAck1,       ack && mOwner);
            chk("mdl_rdata0",   oRData0,     mRD0);
            chk("mdl_rdata1",   oRData1,     mRD1);
        end
    end

    // ---------------- directed stimulus ----------------
    // Issue one request (called at a negedge with the arbiter idle). The
    // request is dropped right after grant; the access must still complete.
    task automatic runTxn(input bit port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output int lat, output int rdCnt, output int wrCnt,
                          output int accCnt);
        logic ackP;
        lat = -1; rdCnt = 0; wrCnt = 0; accCnt = 0;
        if (port) begin
            iReq1 = 1; iWe1 = we; iAddr1 = addr; iWData1 = wdata; iBE1 = be;
        end else begin
            iReq0 = 1; iWe0 = we; iAddr0 = addr; iWData0 = wdata; iBE0 = be;
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge iCLK);
            if (k == 1) begin
                iReq0 = 0; iReq1 = 0;
            end
            if (oMemRead)  rdCnt++;
            if (oMemWrite) wrCnt++;
            if (oAddress == addr && oByteEnable == be) accCnt++;
            ackP = port ? oAck1 : oAck0;
            if (ackP) begin
                lat = k;
                break;
            end
        end
        @(negedge iCLK);
        ackP = port ? oAck1 : oAck0;
        chk("ack_single_pulse", ackP, 1'b0);
    endtask

    int lat, rdc, wrc, accc;
    int order[$];

    initial begin
        // Reset state.
        repeat (3) @(negedge iCLK);
        chk("rst_ack0",    oAck0, 1'b0);
        chk("rst_ack1",    oAck1, 1'b0);
        chk("rst_memRead", oMemRead, 1'b0);
        chk("rst_address", oAddress, 32'h0);
        chk("rst_rdata0",  oRData0, 32'h0);
        chk("rst_rdata1",  oRData1, 32'h0);
        #1 iRST = 0;
        @(negedge iCLK);

        // Single non-SRAM read on port 0, request dropped after grant.
        iMemData = 32'hDEAD_BEEF;
        runTxn(0, 0, 32'h0040_0000, 32'h0, 4'hF, lat, rdc, wrc, accc);
        chk("read_latency", lat, 2);
        chk("read_rdcnt",   rdc, 1);
        chk("read_rdata0",  oRData0, 32'hDEAD_BEEF);

        // Port 1 read so its read-data register holds something.
        iMemData = 32'h1234_5678;
        runTxn(1, 0, 32'h0000_2000, 32'h0, 4'hF, lat, rdc, wrc, accc);
        chk("read1_latency", lat, 2);
        chk("read1_rdata1",  oRData1, 32'h1234_5678);

        // SRAM write on port 1: one write strobe, three access cycles.
        iMemData = 32'hAAAA_5555;
        runTxn(1, 1, 32'h1004_0010, 32'hCAFE_F00D, 4'b0011, lat, rdc, wrc, accc);
        chk("sramw_latency", lat, 4);
        chk("sramw_wrcnt",   wrc, 1);
        chk("sramw_rdcnt",   rdc, 0);
        chk("sramw_acccnt",  accc, 3);
        chk("sramw_rdata1",  oRData1, 32'h1234_5678);
        chk("sramw_rdata0",  oRData0, 32'hDEAD_BEEF);

        // Region boundaries (inclusive).
        iMemData = 32'h0000_0E0D;
        runTxn(0, 0, SEND, 32'h0, 4'hF, lat, rdc, wrc, accc);
        chk("bnd_end_latency", lat, 4);
        chk("bnd_end_rdcnt",   rdc, 3);
        runTxn(0, 0, SEND + 32'd4, 32'h0, 4'hF, lat, rdc, wrc, accc);
        chk("bnd_endp4_latency", lat, 2);
        runTxn(0, 0, SBEGIN, 32'h0, 4'hF, lat, rdc, wrc, accc);
        chk("bnd_begin_latency", lat, 4);
        runTxn(0, 0, SBEGIN - 32'd4, 32'h0, 4'hF, lat, rdc, wrc, accc);
        chk("bnd_beginm4_latency", lat, 2);
        chk("bnd_rdata0", oRData0, 32'h0000_0E0D);

        // Reset in the second SRAM access cycle aborts the transaction.
        iMemData = 32'h5555_AAAA;
        iReq1 = 1; iWe1 = 0; iAddr1 = 32'h1004_0100; iBE1 = 4'hF;
        @(negedge iCLK);
        iReq1 = 0;
        chk("abort_acc1_read", oMemRead, 1'b1);
        @(negedge iCLK);
        chk("abort_acc2_read", oMemRead, 1'b1);
        #2 iRST = 1;
        #1;
        chk("abort_read_drop", oMemRead, 1'b0);
        chk("abort_addr_drop", oAddress, 32'h0);
        chk("abort_be_drop",   oByteEnable, 4'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge iCLK);
            chk("abort_no_ack", oAck1, 1'b0);
        end
        chk("abort_rdata1_cleared", oRData1, 32'h0);
        @(negedge iCLK);
        #2 iRST = 0;

        // Contention: both held, port 0 wins first after reset, then alternate.
        iMemData = 32'h0BAD_F00D;
        iReq0 = 1; iWe0 = 0; iAddr0 = 32'h0000_0100; iBE0 = 4'hF;
        iReq1 = 1; iWe1 = 0; iAddr1 = 32'h0000_0200; iBE1 = 4'hF;
        for (int k = 0; k < 40 && order.size() < 4; k++) begin
            @(negedge iCLK);
            if (oAck0 && oAck1) chk("cont_both_acks", 1'b1, 1'b0);
            if (oAck0) order.push_back(0);
            if (oAck1) order.push_back(1);
        end
        iReq0 = 0; iReq1 = 0;
        chk("cont_count", order.size(), 4);
        if (order.size() == 4) begin
            chk("cont_order0", order[0], 0);
            chk("cont_order1", order[1], 1);
            chk("cont_order2", order[2], 0);
            chk("cont_order3", order[3], 1);
        end
        chk("cont_rdata0", oRData0, 32'h0BAD_F00D);
        repeat (3) @(negedge iCLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
